// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: reset PC, widths, fetch-state
// encoding and the NOP encoding used to clear buffered instruction slots.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          INST_W       = 32;
  localparam int          SRAM_AW      = 20;
  localparam int          ENTRY_W      = 32 + INST_W;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    GAP = 1'b0,
    REQ = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry shift FIFO holding {pc, inst} pairs between fetch and decode.
// Entry 0 is always the head; a pop shifts entry 1 down. When the FIFO
// drains, the head register keeps its last contents.
module fetch_fifo2
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] ent0_q;
  logic [ENTRY_W-1:0] ent1_q;
  logic [1:0]         count_q;
  logic               pop_eff;
  logic               push_eff;

  // A pop of an empty FIFO or a push into a full one (without a pop) is ignored.
  always_comb begin
    pop_eff  = pop & (count_q != 2'd0);
    push_eff = push & ((count_q != 2'd2) | pop_eff);
  end

  // Storage and occupancy update; flush only clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= {32'h0, NOP};
      ent1_q  <= {32'h0, NOP};
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_data;
          else                 ent1_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) ent0_q <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= push_data;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = ent0_q;
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word read at a time
// to the SRAM read controller and buffers results for decode.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   GAP   | mem_req low; wait here until the FIFO has a free slot
//   REQ   | mem_req high; read of pc in flight, waiting for mem_done
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic [SRAM_AW-1:0]  mem_addr,
  input  logic [INST_W-1:0]   mem_rdata,
  input  logic                mem_done,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [INST_W-1:0]   if_inst,
  input  logic                id_ready
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [1:0]         count;
  logic [ENTRY_W-1:0] head;
  logic               pop;
  logic               push;
  logic               slot_free;

  // Handshake glue: a done is only honoured while requesting and without a redirect.
  always_comb begin
    pop       = if_valid & id_ready;
    push      = (state_q == REQ) & mem_done & ~redirect_valid;
    slot_free = (({1'b0, count} - {2'b00, pop}) < 3'd2);
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GAP;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and next-PC logic; redirect has top priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = GAP;
      pc_d    = redirect_pc & ~32'h3;
    end else begin
      case (state_q)
        REQ: begin
          if (mem_done) begin
            state_d = GAP;
            pc_d    = pc_q + 32'd4;
          end
        end
        GAP: begin
          if (slot_free) state_d = REQ;
        end
        default: state_d = GAP;
      endcase
    end
  end

  // Outputs decode directly from registers.
  always_comb begin
    mem_req  = (state_q == REQ);
    mem_addr = pc_q[SRAM_AW+1:2];
    if_valid = (count != 2'd0);
    if_pc    = head[ENTRY_W-1:INST_W];
    if_inst  = head[INST_W-1:0];
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data ({pc_q, mem_rdata}),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: read-controller model answering 4 cycles after
// mem_req rises, plus a scoreboard of expected {pc, inst} pairs.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] DMASK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_done       (mem_done),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Read-controller model: done in the 4th cycle of a continuous request.
  int cnt = 0;
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req !== 1'b1) begin
        cnt       = 0;
        mem_done  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end else begin
        cnt++;
        mem_done  = (cnt == 4);
        mem_rdata = (cnt == 4) ? ({12'h0, mem_addr} ^ DMASK) : 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  logic [63:0] sb_q[$];
  logic [63:0] exp_e;
  logic [31:0] exp_pc = RST_PC;
  logic        last_accept = 1'b0;
  logic        prev_req = 1'b0;
  int          low_run = 0;
  int          n_pop = 0;
  logic [19:0] rise_q[$];
  int          gap_q[$];

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_pc      = RST_PC;
      last_accept = 1'b0;
      prev_req    = 1'b0;
      low_run     = 0;
    end else begin
      chk("done_in_gap", {63'h0, mem_done & ~mem_req}, 64'h0);
      chk("if_valid", {63'h0, if_valid}, {63'h0, sb_q.size() != 0});
      if (last_accept) chk("req_gap", {63'h0, mem_req}, 64'h0);
      if (mem_req) chk("mem_addr", {44'h0, mem_addr}, {44'h0, exp_pc[21:2]});
      if (mem_req && !prev_req) begin
        rise_q.push_back(mem_addr);
        gap_q.push_back(low_run);
      end
      low_run     = mem_req ? 0 : low_run + 1;
      prev_req    = mem_req;
      last_accept = 1'b0;
      if (redirect_valid) begin
        sb_q.delete();
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (if_valid && id_ready) begin
          n_pop++;
          exp_e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
          chk("pop_head", {if_pc, if_inst}, exp_e);
        end
        if (mem_req && mem_done) begin
          sb_q.push_back({exp_pc, {12'h0, exp_pc[21:2]} ^ DMASK});
          exp_pc      = exp_pc + 32'd4;
          last_accept = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = rdy;
    step();
    step();
    rst = 1'b0;
    rise_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (mem_done !== 1'b1 && k < 60) begin step(); k++; end
    chk({tag, "_done_wait"}, {63'h0, mem_done}, 64'h1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (if_valid !== 1'b1 && k < 60) begin step(); k++; end
    chk({tag, "_valid_wait"}, {63'h0, if_valid}, 64'h1);
  endtask

  task automatic wait_cnt(input string tag, input int n);
    int k = 0;
    while (!(mem_req === 1'b1 && cnt == n) && k < 60) begin step(); k++; end
    chk({tag, "_cnt_wait"}, {63'h0, (mem_req === 1'b1 && cnt == n)}, 64'h1);
  endtask

  task automatic wait_pops(input string tag, input int target);
    int k = 0;
    while (n_pop < target && k < 600) begin step(); k++; end
    chk({tag, "_pop_wait"}, {63'h0, n_pop >= target}, 64'h1);
  endtask

  initial begin
    // Reset values and first fetch sequence with one-cycle request gaps
    do_reset(1'b1);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_if_pc", {32'h0, if_pc}, 64'h0);
    chk("rst_if_inst", {32'h0, if_inst}, 64'h0);
    chk("rst_mem_addr", {44'h0, mem_addr}, 64'h0);
    step();
    chk("req_after_rst", {63'h0, mem_req}, 64'h1);
    begin
      int k = 0;
      while (rise_q.size() < 3 && k < 100) begin step(); k++; end
    end
    chk("rise_count", {63'h0, rise_q.size() >= 3}, 64'h1);
    if (rise_q.size() >= 3) begin
      chk("rise_addr0", {44'h0, rise_q[0]}, 64'h0);
      chk("rise_addr1", {44'h0, rise_q[1]}, 64'h1);
      chk("rise_addr2", {44'h0, rise_q[2]}, 64'h2);
      chk("gap1", 64'(gap_q[1]), 64'd1);
      chk("gap2", 64'(gap_q[2]), 64'd1);
    end
    wait_pops("seq", 3);

    // Backpressure: two buffered entries, fetch stalls, one pop restarts it
    do_reset(1'b0);
    repeat (30) step();
    chk("full_mem_req", {63'h0, mem_req}, 64'h0);
    chk("full_if_valid", {63'h0, if_valid}, 64'h1);
    chk("full_head", {if_pc, if_inst}, {RST_PC, DMASK});
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("pop1_head", {if_pc, if_inst}, {RST_PC + 32'd4, DMASK | 32'h1});
    chk("pop1_mem_req", {63'h0, mem_req}, 64'h1);
    chk("pop1_mem_addr", {44'h0, mem_addr}, 64'h2);

    // Redirect while a read is in flight
    do_reset(1'b1);
    wait_pops("redir", n_pop + 2);
    wait_cnt("redir", 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step();
    redirect_valid = 1'b0;
    chk("redir_req_low", {63'h0, mem_req}, 64'h0);
    chk("redir_valid_low", {63'h0, if_valid}, 64'h0);
    step();
    chk("redir_req_high", {63'h0, mem_req}, 64'h1);
    chk("redir_addr", {44'h0, mem_addr}, 64'h40);
    wait_pops("redir_run", n_pop + 3);

    // Redirect coinciding with mem_done while a head is buffered
    do_reset(1'b0);
    wait_valid("rdd");
    wait_done("rdd");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    step();
    redirect_valid = 1'b0;
    chk("rdd_flushed", {63'h0, if_valid}, 64'h0);
    chk("rdd_req_low", {63'h0, mem_req}, 64'h0);
    step();
    chk("rdd_req_high", {63'h0, mem_req}, 64'h1);
    chk("rdd_addr", {44'h0, mem_addr}, 64'h800);
    id_ready = 1'b1;
    wait_pops("rdd_run", n_pop + 2);

    // Simultaneous push and pop with one entry, then a long unbroken stream
    do_reset(1'b0);
    wait_valid("pp");
    wait_done("pp");
    id_ready = 1'b1;
    step();
    chk("pp_valid", {63'h0, if_valid}, 64'h1);
    chk("pp_head", {if_pc, if_inst}, {RST_PC + 32'd4, DMASK | 32'h1});
    id_ready = 1'b0;
    step();
    chk("pp_hold_valid", {63'h0, if_valid}, 64'h1);
    chk("pp_hold_pc", {32'h0, if_pc}, {32'h0, RST_PC + 32'd4});
    id_ready = 1'b1;
    wait_pops("stream", n_pop + 20);

    // Reset pulse during a read
    do_reset(1'b1);
    wait_pops("mrst", n_pop + 1);
    wait_cnt("mrst", 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", {63'h0, mem_req}, 64'h0);
    chk("mrst_valid", {63'h0, if_valid}, 64'h0);
    chk("mrst_addr", {44'h0, mem_addr}, 64'h0);
    step();
    chk("mrst_req_high", {63'h0, mem_req}, 64'h1);
    wait_pops("mrst_run", n_pop + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
